// File: rtl/cv32e40x_tb_mm_status_periph.sv
// Memory-mapped testbench peripheral on the core data OBI port: stdout FIFO,
// test pass/fail/exit reporting, free-running cycle counter and one-shot timer IRQ.
module cv32e40x_tb_mm_status_periph #(
  parameter int unsigned STDOUT_DEPTH  = 16,
  parameter logic [31:0] PRINT_ADDR    = 32'h1000_0000,
  parameter logic [31:0] FIFO_LVL_ADDR = 32'h1000_0004,
  parameter logic [31:0] TIMER_ADDR    = 32'h1500_0000,
  parameter logic [31:0] CYCLE_ADDR    = 32'h1500_0004,
  parameter logic [31:0] STATUS_ADDR   = 32'h2000_0000,
  parameter logic [31:0] EXIT_ADDR     = 32'h2000_0004
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_data_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timer_irq_o
);

  localparam int unsigned AW       = $clog2(STDOUT_DEPTH);
  localparam logic [31:0] PASS_VAL = 32'd123456789;
  localparam logic [31:0] FAIL_VAL = 32'd1;

  typedef enum logic [1:0] {T_IDLE, T_ARMED, T_FIRED} tstate_e;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  // ---------------- decode ----------------
  logic [29:0] w_word;
  logic w_sel_print, w_sel_lvl, w_sel_timer, w_sel_cycle, w_sel_status, w_sel_exit;
  logic w_full_be, w_full, w_gnt, w_wr, w_push, w_pop, w_twr, w_unused;

  assign w_word       = data_addr_i[31:2];
  assign w_unused     = ^data_addr_i[1:0];
  assign w_sel_print  = (w_word == PRINT_ADDR[31:2]);
  assign w_sel_lvl    = (w_word == FIFO_LVL_ADDR[31:2]);
  assign w_sel_timer  = (w_word == TIMER_ADDR[31:2]);
  assign w_sel_cycle  = (w_word == CYCLE_ADDR[31:2]);
  assign w_sel_status = (w_word == STATUS_ADDR[31:2]);
  assign w_sel_exit   = (w_word == EXIT_ADDR[31:2]);
  assign w_full_be    = (data_be_i == 4'hF);

  // Stall on registered occupancy only, so a same-cycle pop never frees the slot early.
  assign w_gnt  = data_req_i && !(data_we_i && w_sel_print && w_full);
  assign w_wr   = w_gnt && data_we_i;
  assign w_push = w_wr && w_sel_print && data_be_i[0];
  assign w_twr  = w_wr && w_sel_timer && w_full_be;
  assign data_gnt_o = w_gnt;

  // ---------------- stdout FIFO ----------------
  logic [7:0]  r_mem [STDOUT_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;

  assign w_full = (r_cnt == (AW+1)'(STDOUT_DEPTH));
  assign w_pop  = (r_cnt != '0) && stdout_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_wdata_i[7:0];
  end

  assign stdout_valid_o = (r_cnt != '0);
  assign stdout_data_o  = stdout_valid_o ? r_mem[r_rptr] : 8'h00;

  // ---------------- cycle counter ----------------
  logic [31:0] r_cyc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cyc <= '0;
    else         r_cyc <= r_cyc + 32'd1;
  end

  // ---------------- timer ----------------
  tstate_e     r_tstate, w_tstate_nxt;
  logic [31:0] r_tcnt, w_tcnt_nxt;
  logic        r_irq;

  always_comb begin
    w_tstate_nxt = r_tstate;
    w_tcnt_nxt   = r_tcnt;
    if (w_twr) begin
      w_tcnt_nxt   = data_wdata_i;
      w_tstate_nxt = (data_wdata_i != '0) ? T_ARMED : T_IDLE;
    end else if (r_tstate == T_ARMED) begin
      w_tcnt_nxt = r_tcnt - 32'd1;
      if (r_tcnt == 32'd1) w_tstate_nxt = T_FIRED;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tstate <= T_IDLE;
      r_tcnt   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_tstate <= w_tstate_nxt;
      r_tcnt   <= w_tcnt_nxt;
      // irq trails FIRED by one cycle; a timer write drops it right away
      r_irq    <= (r_tstate == T_FIRED) && !w_twr;
    end
  end

  assign timer_irq_o = r_irq;

  // ---------------- response ----------------
  rsp_t w_rsp, r_rsp;
  logic r_rvalid;

  always_comb begin
    w_rsp = '0;
    if (w_sel_cycle) begin
      if (data_we_i) w_rsp.err = 1'b1;
      else           w_rsp.rdata = r_cyc;
    end else if (w_sel_lvl) begin
      if (data_we_i) w_rsp.err = 1'b1;
      else           w_rsp.rdata = 32'(r_cnt);
    end else if (w_sel_timer) begin
      if (!data_we_i) w_rsp.rdata = r_tcnt;
    end else if (!(w_sel_print || w_sel_status || w_sel_exit)) begin
      w_rsp.err = 1'b1;
    end
  end

  logic        r_pass, r_fail, r_exit_vld;
  logic [31:0] r_exit_val;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid   <= 1'b0;
      r_rsp      <= '0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_exit_vld <= 1'b0;
      r_exit_val <= '0;
    end else begin
      r_rvalid   <= w_gnt;
      r_rsp      <= w_gnt ? w_rsp : '0;
      r_pass     <= w_wr && w_sel_status && w_full_be && (data_wdata_i == PASS_VAL);
      r_fail     <= w_wr && w_sel_status && w_full_be && (data_wdata_i == FAIL_VAL);
      r_exit_vld <= w_wr && w_sel_exit && w_full_be;
      if (w_wr && w_sel_exit && w_full_be) r_exit_val <= data_wdata_i;
    end
  end

  assign data_rvalid_o  = r_rvalid;
  assign data_rdata_o   = r_rsp.rdata;
  assign data_err_o     = r_rsp.err;
  assign tests_passed_o = r_pass;
  assign tests_failed_o = r_fail;
  assign exit_valid_o   = r_exit_vld;
  assign exit_value_o   = r_exit_val;

endmodule
